clock_meter: RTL
================

CLOCK_METER -- requirements
Module: clock_meter

Interface
REQ-001 Parameter CNT_W, default 28, SHALL set the width of all counters and results.
REQ-002 Parameter TIMEOUT, default 28'd50000000, SHALL set the clock_in cycles without a rising edge before the stuck condition is declared.
REQ-003 clock_in  input  1  SHALL be the single system clock; all state is updated on its rising edge.
REQ-004 reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 sig_in  input  1  SHALL be the slow, asynchronous signal under measurement, typically a divided clock.
REQ-006 meas_ready  input  1  SHALL be the consumer's acceptance of the current result.
REQ-007 meas_valid  output  1  SHALL indicate that period, high_time and overrun hold a result.
REQ-008 period  output  CNT_W  SHALL be the clock_in cycles between two successive detected rising edges.
REQ-009 high_time  output  CNT_W  SHALL be the clock_in cycles from a rising edge to the following falling edge.
REQ-010 overrun  output  1  SHALL be set when an unaccepted result was overwritten.
REQ-011 stuck  output  1  SHALL be set when no rising edge has arrived within TIMEOUT cycles.

Function
REQ-012 sig_in SHALL pass through a 2-flop synchronizer plus one history flop; an edge SHALL be detected 3 clock_in cycles after sig_in changes.
REQ-013 FSM states SHALL be IDLE and COUNT.
REQ-014 In IDLE, a detected rising edge SHALL move the FSM to COUNT and load the counter with 1; no result is produced.
REQ-015 In COUNT, the counter SHALL increment by 1 every cycle and saturate at 2^CNT_W-1 without wrapping.
REQ-016 In COUNT, a detected falling edge SHALL copy the counter value into an internal high-time register.
REQ-017 In COUNT, a detected rising edge SHALL, in the same cycle:
  - load period with the counter value;
  - load high_time with the high-time register;
  - set meas_valid;
  - reload the counter with 1.
REQ-018 A signal of period N cycles with a high phase of H cycles SHALL yield period=N and high_time=H.
REQ-019 Handshake: a result is accepted in a cycle where meas_valid=1 and meas_ready=1; meas_valid SHALL clear on the next edge unless a new result is published in that same cycle.
REQ-020 Simultaneous accept and publish SHALL leave meas_valid=1 with the new values and overrun=0.
REQ-021 A publish while meas_valid=1 and meas_ready=0 SHALL overwrite the outputs and set overrun; overrun SHALL stay set until that result is accepted.
REQ-022 Timeout: if the counter reaches TIMEOUT in COUNT or IDLE, the FSM SHALL go to IDLE and stuck SHALL be set.
  - The counter SHALL also count in IDLE for this purpose, holding at TIMEOUT.
  - meas_valid and the result registers SHALL be unaffected.
REQ-023 stuck SHALL clear on the next detected rising edge.
REQ-024 Outputs SHALL change only on clock_in rising edges or on reset.

Reset
REQ-025 On reset_n=0, the block SHALL immediately reach this state:
  - FSM in IDLE;
  - counter, high-time register, period and high_time at 0;
  - meas_valid, overrun and stuck at 0;
  - synchronizer flops at 0.
REQ-026 Reset mid-measurement SHALL discard the partial count; the first result after release requires two rising edges.

Configuration
REQ-027 With CLOCK_METER_GLITCH_FILTER_EN defined, the synchronized level SHALL be accepted only after 3 consecutive equal samples, adding 2 cycles of edge latency; pulses shorter than 3 cycles SHALL be ignored.
REQ-028 Without CLOCK_METER_GLITCH_FILTER_EN, every synchronized transition SHALL be treated as an edge, per REQ-012.

Structure
REQ-029 Package clock_meter_pkg SHALL hold the FSM state enum (IDLE, COUNT) and the default CNT_W and TIMEOUT constants.
REQ-030 Synchronizer, optional glitch filter and edge detection SHALL live in sub-module sync_edge, which outputs rise and fall pulses.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
  - sig_in period 10, high 5, meas_ready=1 -> meas_valid pulses once per period, with period=10 and high_time=5 from the second rising edge onward.
  - sig_in period 7, high 2, meas_ready=0 for 3 periods -> outputs track the latest result, overrun=1; raising meas_ready clears meas_valid and overrun the next cycle.
  - TIMEOUT=100, sig_in held low after one period -> stuck=1 exactly 100 cycles after the last rising-edge reload; the next rising edge clears stuck without publishing.
  - reset_n asserted mid-period, then released -> all outputs 0 immediately; the first meas_valid follows the second post-reset rising edge.
  - With CLOCK_METER_GLITCH_FILTER_EN, a 2-cycle high glitch -> no edge and no result; a 3-cycle pulse -> high_time=3.
  - CNT_W=4, period 20 -> period=15 (saturation).

Source files
------------

// File: rtl/clock_meter_pkg.sv
// Shared types and default constants for the clock_meter block.
package clock_meter_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } meter_state_t;

    localparam int unsigned DEF_CNT_W   = 28;
    localparam int unsigned DEF_TIMEOUT = 28'd50000000;

endpackage

// File: rtl/clock_meter_sync_edge.sv
// Synchronizer, optional glitch filter (CLOCK_METER_GLITCH_FILTER_EN) and edge detector.
module sync_edge (
    input  logic clock_in,
    input  logic reset_n,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic hist;
    logic lvl;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
        end
    end

`ifdef CLOCK_METER_GLITCH_FILTER_EN
    logic g0;
    logic g1;

    // The accepted level only moves once three consecutive samples agree.
    always_comb begin
        lvl = hist;
        if ((s2 == g0) && (g0 == g1))
            lvl = s2;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            g0   <= 1'b0;
            g1   <= 1'b0;
            hist <= 1'b0;
        end else begin
            g0   <= s2;
            g1   <= g0;
            hist <= lvl;
        end
    end
`else
    always_comb lvl = s2;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n)
            hist <= 1'b0;
        else
            hist <= lvl;
    end
`endif

    always_comb begin
        rise = lvl & ~hist;
        fall = ~lvl & hist;
    end

endmodule

// File: rtl/clock_meter.sv
// Measures period and high time of a slow signal in clock_in cycles, with
// valid/ready result handshake, overrun flag and stuck-signal timeout.
module clock_meter
    import clock_meter_pkg::*;
#(
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             overrun,
    output logic             stuck
);

    // A TIMEOUT beyond the counter range can never be reached.
    localparam bit               TO_REACH = ((64'(TIMEOUT) >> CNT_W) == 64'd0);
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    meter_state_t     state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hi_reg;
    logic [CNT_W-1:0] cnt_inc;
    logic             timed_out;
    logic             rise;
    logic             fall;

    sync_edge u_sync_edge (
        .clock_in (clock_in),
        .reset_n  (reset_n),
        .sig_in   (sig_in),
        .rise     (rise),
        .fall     (fall)
    );

    always_comb begin
        timed_out = TO_REACH && (cnt == TO_VAL);
        cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            hi_reg     <= '0;
            period     <= '0;
            high_time  <= '0;
            meas_valid <= 1'b0;
            overrun    <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            // Acceptance first; a publish below in the same cycle takes priority.
            if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
                overrun    <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (rise) begin
                        state <= COUNT;
                        cnt   <= CNT_ONE;
                        stuck <= 1'b0;
                    end else if (timed_out) begin
                        stuck <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                COUNT: begin
                    if (fall)
                        hi_reg <= cnt;
                    if (rise) begin
                        period     <= cnt;
                        high_time  <= hi_reg;
                        meas_valid <= 1'b1;
                        overrun    <= meas_valid && !meas_ready;
                        cnt        <= CNT_ONE;
                        stuck      <= 1'b0;
                    end else if (timed_out) begin
                        state <= IDLE;
                        stuck <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
